// File: rtl/sl_fifo_responder.sv
// USB-controller side of the 32-bit slave-FIFO bus: answers the bridge's strobes,
// buffers F2U/U2F words, and exposes both buffers to host-side streams.
module sl_fifo_responder #(
  parameter int DEPTH    = 512,
  parameter int WMARK    = 4,
  parameter int RD_LAT   = 2,
  parameter int FLAG_LAT = 3
)(
  input  logic        SYS_CLK,
  input  logic        SYS_RST,
  input  logic        SL_CS_N,
  input  logic [1:0]  SL_AD,
  input  logic        SL_WR_N,
  input  logic        SL_RD_N,
  input  logic        SL_OE_N,
  input  logic        SL_PKTEND_N,
  input  logic [31:0] SL_DT_I,
  output logic [31:0] SL_DT_O,
  output logic        SL_DT_OE,
  output logic        SL_FLAGA,
  output logic        SL_FLAGB,
  output logic        SL_FLAGC,
  output logic        SL_FLAGD,
  input  logic        HOST_TX_VALID,
  output logic        HOST_TX_READY,
  input  logic [31:0] HOST_TX_DATA,
  output logic        HOST_RX_VALID,
  input  logic        HOST_RX_READY,
  output logic [31:0] HOST_RX_DATA,
  output logic        HOST_RX_LAST,
  output logic        HOST_RX_ZLP,
  output logic        ERR_OVF,
  output logic        ERR_UDF,
  output logic        ERR_PROTO
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic sel, proto, wr_req, zlp_req, rd_req;
  assign sel     = ~SL_CS_N;
  // Simultaneous RD/WR only counts as a protocol error on the two live sockets.
  assign proto   = sel & ~SL_RD_N & ~SL_WR_N & ((SL_AD == 2'b00) | (SL_AD == 2'b11));
  assign wr_req  = sel & ~SL_WR_N & (SL_AD == 2'b00) & ~proto;
  assign zlp_req = sel & ~SL_PKTEND_N & SL_WR_N & (SL_AD == 2'b00);
  assign rd_req  = sel & ~SL_RD_N & (SL_AD == 2'b11) & ~proto;

  // F2U buffer: entries are {zlp, last, data}
  logic [33:0] f2u_mem [DEPTH];
  ptr_t f2u_wp_q, f2u_rp_q, f2u_wp_d, f2u_rp_d, f2u_cnt_d;
  logic f2u_full, f2u_empty, f2u_push_req, f2u_push, f2u_pop;
  logic [33:0] f2u_head, f2u_wdata;

  assign f2u_empty    = (f2u_wp_q == f2u_rp_q);
  assign f2u_full     = (f2u_wp_q[AW] != f2u_rp_q[AW]) && (f2u_wp_q[AW-1:0] == f2u_rp_q[AW-1:0]);
  assign f2u_pop      = HOST_RX_VALID & HOST_RX_READY;
  assign f2u_push_req = wr_req | zlp_req;
  assign f2u_push     = f2u_push_req & (~f2u_full | f2u_pop);
  assign f2u_wp_d     = f2u_wp_q + ptr_t'(f2u_push);
  assign f2u_rp_d     = f2u_rp_q + ptr_t'(f2u_pop);
  assign f2u_cnt_d    = f2u_wp_d - f2u_rp_d;
  assign f2u_wdata    = zlp_req ? {2'b11, 32'h0} : {1'b0, ~SL_PKTEND_N, SL_DT_I};
  assign f2u_head     = f2u_mem[f2u_rp_q[AW-1:0]];

  assign HOST_RX_VALID = ~f2u_empty & ~SYS_RST;
  assign HOST_RX_DATA  = HOST_RX_VALID ? f2u_head[31:0] : 32'h0;
  assign HOST_RX_LAST  = HOST_RX_VALID & f2u_head[32];
  assign HOST_RX_ZLP   = HOST_RX_VALID & f2u_head[33];

  // U2F buffer
  logic [31:0] u2f_mem [DEPTH];
  ptr_t u2f_wp_q, u2f_rp_q, u2f_wp_d, u2f_rp_d, u2f_cnt_d;
  logic u2f_full, u2f_empty, u2f_push, u2f_pop, u2f_udf;
  logic [31:0] rd_data;

  assign u2f_empty     = (u2f_wp_q == u2f_rp_q);
  assign u2f_full      = (u2f_wp_q[AW] != u2f_rp_q[AW]) && (u2f_wp_q[AW-1:0] == u2f_rp_q[AW-1:0]);
  assign HOST_TX_READY = ~u2f_full & ~SYS_RST;
  assign u2f_push      = HOST_TX_VALID & HOST_TX_READY;
  assign u2f_pop       = rd_req & ~u2f_empty;
  assign u2f_udf       = rd_req & u2f_empty;
  assign u2f_wp_d      = u2f_wp_q + ptr_t'(u2f_push);
  assign u2f_rp_d      = u2f_rp_q + ptr_t'(u2f_pop);
  assign u2f_cnt_d     = u2f_wp_d - u2f_rp_d;
  assign rd_data       = u2f_pop ? u2f_mem[u2f_rp_q[AW-1:0]] : 32'h0;

  always_ff @(posedge SYS_CLK) begin
    if (f2u_push) f2u_mem[f2u_wp_q[AW-1:0]] <= f2u_wdata;
    if (u2f_push) u2f_mem[u2f_wp_q[AW-1:0]] <= HOST_TX_DATA;
  end

  // Raw flags reflect occupancy after this cycle's push/pop.
  logic [3:0] flag_raw;
  assign flag_raw[0] = (f2u_cnt_d != ptr_t'(DEPTH));
  assign flag_raw[1] = ((ptr_t'(DEPTH) - f2u_cnt_d) >= ptr_t'(WMARK));
  assign flag_raw[2] = (u2f_cnt_d != '0);
  assign flag_raw[3] = (u2f_cnt_d >= ptr_t'(WMARK));

  logic [FLAG_LAT-1:0][3:0] flag_pipe_q;
  logic [RD_LAT-1:0]        rd_vld_q;
  logic [RD_LAT-1:0][31:0]  rd_dat_q;
  logic [31:0]              dout_hold_q;
  logic                     oe_q, ovf_q, udf_q, proto_q;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      f2u_wp_q    <= '0;
      f2u_rp_q    <= '0;
      u2f_wp_q    <= '0;
      u2f_rp_q    <= '0;
      flag_pipe_q <= '0;
      rd_vld_q    <= '0;
      rd_dat_q    <= '0;
      dout_hold_q <= '0;
      oe_q        <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      proto_q     <= 1'b0;
    end else begin
      f2u_wp_q       <= f2u_wp_d;
      f2u_rp_q       <= f2u_rp_d;
      u2f_wp_q       <= u2f_wp_d;
      u2f_rp_q       <= u2f_rp_d;
      flag_pipe_q[0] <= flag_raw;
      for (int i = 1; i < FLAG_LAT; i++) flag_pipe_q[i] <= flag_pipe_q[i-1];
      // Underflow reads travel the pipe as valid zero words so timing matches real reads.
      rd_vld_q[0] <= rd_req;
      rd_dat_q[0] <= rd_data;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_dat_q[i] <= rd_dat_q[i-1];
      end
      dout_hold_q <= SL_DT_O;
      oe_q        <= sel & ~SL_OE_N & (SL_AD == 2'b11);
      ovf_q       <= ovf_q | (f2u_push_req & ~f2u_push);
      udf_q       <= udf_q | u2f_udf;
      proto_q     <= proto_q | proto;
    end
  end

  assign SL_DT_O   = rd_vld_q[RD_LAT-1] ? rd_dat_q[RD_LAT-1] : dout_hold_q;
  assign SL_DT_OE  = oe_q;
  assign SL_FLAGA  = flag_pipe_q[FLAG_LAT-1][0];
  assign SL_FLAGB  = flag_pipe_q[FLAG_LAT-1][1];
  assign SL_FLAGC  = flag_pipe_q[FLAG_LAT-1][2];
  assign SL_FLAGD  = flag_pipe_q[FLAG_LAT-1][3];
  assign ERR_OVF   = ovf_q;
  assign ERR_UDF   = udf_q;
  assign ERR_PROTO = proto_q;
endmodule

// File: tb/tb_sl_fifo_responder.sv
// Directed bench for sl_fifo_responder: table-driven read burst plus hand sequences
// for packet end/ZLP, overflow, protocol errors, underflow and mid-burst reset.
module tb_sl_fifo_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n, wr_n, rd_n, oe_n, pkt_n;
  logic [1:0]  ad;
  logic [31:0] dt_i, dt_o;
  logic        dt_oe, fa, fb, fc, fd;
  logic        tx_v, tx_r, rx_v, rx_r, rx_last, rx_zlp;
  logic [31:0] tx_d, rx_d;
  logic        e_ovf, e_udf, e_proto;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sl_fifo_responder #(.DEPTH(512), .WMARK(4), .RD_LAT(2), .FLAG_LAT(3)) dut (
    .SYS_CLK(clk), .SYS_RST(rst), .SL_CS_N(cs_n), .SL_AD(ad), .SL_WR_N(wr_n),
    .SL_RD_N(rd_n), .SL_OE_N(oe_n), .SL_PKTEND_N(pkt_n), .SL_DT_I(dt_i),
    .SL_DT_O(dt_o), .SL_DT_OE(dt_oe), .SL_FLAGA(fa), .SL_FLAGB(fb),
    .SL_FLAGC(fc), .SL_FLAGD(fd), .HOST_TX_VALID(tx_v), .HOST_TX_READY(tx_r),
    .HOST_TX_DATA(tx_d), .HOST_RX_VALID(rx_v), .HOST_RX_READY(rx_r),
    .HOST_RX_DATA(rx_d), .HOST_RX_LAST(rx_last), .HOST_RX_ZLP(rx_zlp),
    .ERR_OVF(e_ovf), .ERR_UDF(e_udf), .ERR_PROTO(e_proto)
  );

  typedef struct {
    logic        cs_n;
    logic [1:0]  ad;
    logic        rd_n;
    logic        oe_n;
    logic [31:0] e_dout;
    logic        e_oe;
    logic        e_fc;
    logic        e_fd;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; oe_n = 1'b1; pkt_n = 1'b1;
    ad = 2'b00; dt_i = 32'h0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_drained, bad;

    // 8-word read burst from U2F holding 0x100..0x107; RD_LAT=2, FLAG_LAT=3
    tbl[0]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'h100, 1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'h101, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'h102, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'h103, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'h104, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'h105, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'b11, 1'b0, 1'b0, 32'h106, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 2'b11, 1'b1, 1'b0, 32'h107, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 1'b1, 1'b0, 32'h107, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'b11, 1'b1, 1'b0, 32'h107, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'b11, 1'b1, 1'b0, 32'h107, 1'b0, 1'b0, 1'b0};

    bus_idle();
    tx_v = 1'b0; tx_d = 32'h0; rx_r = 1'b0; rst = 1'b1;
    cyc(3);
    chk("rst_flaga", {31'h0, fa}, 0);
    chk("rst_tx_ready", {31'h0, tx_r}, 0);
    chk("rst_dt_oe", {31'h0, dt_oe}, 0);
    chk("rst_dt_o", dt_o, 0);
    chk("rst_err", {29'h0, e_ovf, e_udf, e_proto}, 0);

    rst = 1'b0;
    cyc(1); chk("flaga_lat1", {31'h0, fa}, 0);
    cyc(1); chk("flaga_lat2", {31'h0, fa}, 0);
    cyc(1);
    chk("flaga_lat3", {31'h0, fa}, 1);
    chk("flagb_lat3", {31'h0, fb}, 1);
    chk("flagc_init", {31'h0, fc}, 0);
    chk("flagd_init", {31'h0, fd}, 0);
    chk("tx_ready_init", {31'h0, tx_r}, 1);

    // host fills U2F, master reads it back-to-back
    for (int i = 0; i < 8; i++) begin
      tx_v = 1'b1; tx_d = 32'h100 + i; cyc(1);
    end
    tx_v = 1'b0;
    cyc(4);
    chk("u2f_flagc_set", {31'h0, fc}, 1);
    chk("u2f_flagd_set", {31'h0, fd}, 1);
    for (int k = 0; k < 12; k++) begin
      cs_n = tbl[k].cs_n; ad = tbl[k].ad; rd_n = tbl[k].rd_n; oe_n = tbl[k].oe_n;
      cyc(1);
      chk($sformatf("rd_dout[%0d]", k), dt_o, tbl[k].e_dout);
      chk($sformatf("rd_oe[%0d]", k), {31'h0, dt_oe}, {31'h0, tbl[k].e_oe});
      chk($sformatf("rd_flagc[%0d]", k), {31'h0, fc}, {31'h0, tbl[k].e_fc});
      chk($sformatf("rd_flagd[%0d]", k), {31'h0, fd}, {31'h0, tbl[k].e_fd});
    end
    bus_idle();
    cyc(2);
    chk("burst_no_udf", {31'h0, e_udf}, 0);

    // 3-word packet with PKTEND on the last word, then a ZLP
    cs_n = 1'b0; ad = 2'b00;
    for (int i = 0; i < 3; i++) begin
      wr_n = 1'b0; dt_i = 32'hA0 + i; pkt_n = (i == 2) ? 1'b0 : 1'b1;
      cyc(1);
    end
    wr_n = 1'b1; pkt_n = 1'b0; dt_i = 32'h0;
    cyc(1);
    bus_idle();
    cyc(1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pkt_valid[%0d]", i), {31'h0, rx_v}, 1);
      chk($sformatf("pkt_data[%0d]", i), rx_d, (i == 3) ? 32'h0 : 32'hA0 + i);
      chk($sformatf("pkt_last[%0d]", i), {31'h0, rx_last}, (i >= 2) ? 1 : 0);
      chk($sformatf("pkt_zlp[%0d]", i), {31'h0, rx_zlp}, (i == 3) ? 1 : 0);
      rx_r = 1'b1;
      cyc(1);
    end
    chk("pkt_drained", {31'h0, rx_v}, 0);
    rx_r = 1'b0;

    // protocol error, unused sockets, read of a word then of an empty U2F
    tx_v = 1'b1; tx_d = 32'h55; cyc(1); tx_v = 1'b0;
    cs_n = 1'b0; ad = 2'b00; wr_n = 1'b0; rd_n = 1'b0; dt_i = 32'hDEAD;
    cyc(1);
    chk("proto_set", {31'h0, e_proto}, 1);
    ad = 2'b11; cyc(1);
    rd_n = 1'b1; ad = 2'b01; cyc(1);
    ad = 2'b10; cyc(1);
    bus_idle(); cyc(1);
    chk("proto_no_push", {31'h0, rx_v}, 0);
    chk("unused_ad_no_ovf", {31'h0, e_ovf}, 0);
    chk("proto_no_udf", {31'h0, e_udf}, 0);
    cs_n = 1'b0; ad = 2'b11; oe_n = 1'b0; rd_n = 1'b0; cyc(1);
    rd_n = 1'b1; cyc(1);
    chk("proto_no_pop", dt_o, 32'h55);
    rd_n = 1'b0; cyc(1);
    chk("udf_set", {31'h0, e_udf}, 1);
    rd_n = 1'b1; cyc(1);
    chk("udf_zero_data", dt_o, 32'h0);
    bus_idle(); cyc(1);

    // overflow: 515 writes into a 512-deep F2U with the host stalled
    cs_n = 1'b0; ad = 2'b00; rx_r = 1'b0;
    for (int i = 0; i < 515; i++) begin
      wr_n = 1'b0; dt_i = i; cyc(1);
      if (i == 509) chk("ovf_flagb_before", {31'h0, fb}, 1);
      if (i == 510) chk("ovf_flagb_after", {31'h0, fb}, 0);
      if (i == 511) begin
        chk("ovf_not_yet", {31'h0, e_ovf}, 0);
        chk("ovf_flaga_early", {31'h0, fa}, 1);
      end
      if (i == 512) begin
        chk("ovf_set", {31'h0, e_ovf}, 1);
        chk("ovf_flaga_lat2", {31'h0, fa}, 1);
      end
      if (i == 513) chk("ovf_flaga_lat3", {31'h0, fa}, 0);
    end
    bus_idle(); cyc(1);
    rx_r = 1'b1;
    n_drained = 0; bad = 0;
    for (int g = 0; g < 600 && rx_v; g++) begin
      if (rx_d !== n_drained || rx_last !== 1'b0) bad++;
      n_drained++;
      cyc(1);
    end
    rx_r = 1'b0;
    chk("ovf_stored_count", n_drained, 512);
    chk("ovf_stored_data_bad", bad, 0);

    // reset mid read burst with F2U and U2F both populated
    cs_n = 1'b0; ad = 2'b00; wr_n = 1'b0; dt_i = 32'h77; cyc(2);
    bus_idle();
    for (int i = 0; i < 10; i++) begin
      tx_v = 1'b1; tx_d = 32'h200 + i; cyc(1);
    end
    tx_v = 1'b0; cyc(4);
    chk("pre_rst_rx_valid", {31'h0, rx_v}, 1);
    cs_n = 1'b0; ad = 2'b11; oe_n = 1'b0; rd_n = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) rst = 1'b1;
      cyc(1);
      if (k == 4) break;
    end
    chk("midrst_dt_oe", {31'h0, dt_oe}, 0);
    chk("midrst_dt_o", dt_o, 0);
    chk("midrst_rx_valid", {31'h0, rx_v}, 0);
    chk("midrst_err", {29'h0, e_ovf, e_udf, e_proto}, 0);
    bus_idle(); rst = 1'b0;
    cyc(4);
    chk("postrst_flaga", {31'h0, fa}, 1);
    chk("postrst_flagc", {31'h0, fc}, 0);
    chk("postrst_rx_valid", {31'h0, rx_v}, 0);
    chk("postrst_err", {29'h0, e_ovf, e_udf, e_proto}, 0);
    cs_n = 1'b0; ad = 2'b11; rd_n = 1'b0; cyc(1);
    chk("postrst_u2f_flushed", {31'h0, e_udf}, 1);
    bus_idle(); cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
